// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipelined_cla_adder                                             |
// | Purpose  : Pipelined carry-lookahead add/subtract, one SLICE per stage,    |
// |            valid/ready handshake with global stall. Optional NZCV flags    |
// |            enabled by defining ALU_FLAGS_EN.                               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pipelined_cla_adder #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             G,
    output logic             P,
    output logic [3:0]       flags
);

    localparam int c_STAGES = WIDTH / SLICE;
    localparam int c_LO_TOT = SLICE * c_STAGES * (c_STAGES + 1) / 2;
    localparam int c_HI_TOT = (c_STAGES - 1) * WIDTH - SLICE * (c_STAGES - 1) * c_STAGES / 2;
    localparam int c_HI_W   = (c_HI_TOT > 0) ? c_HI_TOT : 1;

    if ((WIDTH % SLICE != 0) || (SLICE % 4 != 0)) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a multiple of SLICE and SLICE a multiple of 4");
    end

    // Returns {carry_out, slice_G, slice_P, sum} built from 4-bit lookahead groups.
    function automatic logic [SLICE+2:0] f_cla_slice(input logic [SLICE-1:0] x,
                                                     input logic [SLICE-1:0] y,
                                                     input logic             ci);
        logic [3:0]       gi;
        logic [3:0]       pi;
        logic [SLICE-1:0] sm;
        logic             c;
        logic             gg;
        logic             sg;
        logic             sp;
        c  = ci;
        sg = 1'b0;
        sp = 1'b1;
        sm = '0;
        for (int j = 0; j < SLICE / 4; j++) begin
            gi = x[4*j +: 4] & y[4*j +: 4];
            pi = x[4*j +: 4] ^ y[4*j +: 4];
            sm[4*j +: 4] = pi ^ {gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & c),
                                 gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c),
                                 gi[0] | (pi[0] & c),
                                 c};
            gg = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
            c  = gg | (&pi & c);
            sg = gg | (&pi & sg);
            sp = sp & (&pi);
        end
        return {c, sg, sp, sm};
    endfunction

    logic [WIDTH-1:0]    w_b_eff;
    logic                w_adv;
    logic [c_STAGES-1:0] w_v;
    logic [c_STAGES-1:0] w_c;
    logic [c_STAGES-1:0] w_g;
    logic [c_STAGES-1:0] w_p;
    logic [c_LO_TOT-1:0] w_lo;
    logic [c_HI_W-1:0]   w_hi_a;
    logic [c_HI_W-1:0]   w_hi_b;
`ifdef ALU_FLAGS_EN
    logic [c_STAGES-1:0] w_z;
    logic                w_ovf;
`endif

    assign w_b_eff = sub ? ~b : b;
    assign w_adv   = ~w_v[c_STAGES-1] | out_ready;

    if (c_HI_TOT == 0) begin : g_no_hi
        assign w_hi_a = 1'b0;
        assign w_hi_b = 1'b0;
    end

    // Finished sums and unconsumed operands are packed per stage into w_lo / w_hi_*.
    genvar k;
    for (k = 0; k < c_STAGES; k++) begin : g_stage
        localparam int c_OP_W     = WIDTH - k * SLICE;
        localparam int c_LO_W     = (k + 1) * SLICE;
        localparam int c_LO_OFF   = SLICE * k * (k + 1) / 2;
        localparam int c_PLO_OFF  = SLICE * (k - 1) * k / 2;
        localparam int c_HI_OFF   = k * WIDTH - SLICE * k * (k + 1) / 2;
        localparam int c_PHI_OFF  = (k - 1) * WIDTH - SLICE * (k - 1) * k / 2;

        logic              w_vi;
        logic              w_ci;
        logic              w_gi;
        logic              w_pi;
        logic [c_OP_W-1:0] w_op_a;
        logic [c_OP_W-1:0] w_op_b;
        logic [c_LO_W-1:0] w_lo_next;
        logic [SLICE+2:0]  w_slc;
        logic              r_v;
        logic              r_c;
        logic              r_g;
        logic              r_p;
        logic [c_LO_W-1:0] r_lo;

        if (k == 0) begin : g_first
            assign w_vi      = in_valid;
            assign w_ci      = cin;
            assign w_gi      = 1'b0;
            assign w_pi      = 1'b1;
            assign w_op_a    = a;
            assign w_op_b    = w_b_eff;
            assign w_lo_next = w_slc[SLICE-1:0];
        end else begin : g_next
            assign w_vi      = w_v[k-1];
            assign w_ci      = w_c[k-1];
            assign w_gi      = w_g[k-1];
            assign w_pi      = w_p[k-1];
            assign w_op_a    = w_hi_a[c_PHI_OFF +: c_OP_W];
            assign w_op_b    = w_hi_b[c_PHI_OFF +: c_OP_W];
            assign w_lo_next = {w_slc[SLICE-1:0], w_lo[c_PLO_OFF +: k*SLICE]};
        end

        assign w_slc = f_cla_slice(w_op_a[SLICE-1:0], w_op_b[SLICE-1:0], w_ci);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_v  <= 1'b0;
                r_c  <= 1'b0;
                r_g  <= 1'b0;
                r_p  <= 1'b0;
                r_lo <= '0;
            end else if (w_adv) begin
                r_v  <= w_vi;
                r_c  <= w_slc[SLICE+2];
                r_g  <= w_slc[SLICE+1] | (w_slc[SLICE] & w_gi);
                r_p  <= w_slc[SLICE] & w_pi;
                r_lo <= w_lo_next;
            end
        end

        assign w_v[k] = r_v;
        assign w_c[k] = r_c;
        assign w_g[k] = r_g;
        assign w_p[k] = r_p;
        assign w_lo[c_LO_OFF +: c_LO_W] = r_lo;

        if (k < c_STAGES - 1) begin : g_hi
            localparam int c_HW = c_OP_W - SLICE;
            logic [c_HW-1:0] r_ha;
            logic [c_HW-1:0] r_hb;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ha <= '0;
                    r_hb <= '0;
                end else if (w_adv) begin
                    r_ha <= w_op_a[c_OP_W-1:SLICE];
                    r_hb <= w_op_b[c_OP_W-1:SLICE];
                end
            end
            assign w_hi_a[c_HI_OFF +: c_HW] = r_ha;
            assign w_hi_b[c_HI_OFF +: c_HW] = r_hb;
        end

`ifdef ALU_FLAGS_EN
        logic w_zi;
        logic r_z;
        if (k == 0) begin : g_zfirst
            assign w_zi = 1'b1;
        end else begin : g_znext
            assign w_zi = w_z[k-1];
        end
        always_ff @(posedge clk) begin
            if (rst)        r_z <= 1'b0;
            else if (w_adv) r_z <= w_zi & ~|w_slc[SLICE-1:0];
        end
        assign w_z[k] = r_z;

        // The top slice still holds both operand sign bits for overflow.
        if (k == c_STAGES - 1) begin : g_ovf
            logic r_ovf;
            always_ff @(posedge clk) begin
                if (rst)        r_ovf <= 1'b0;
                else if (w_adv) r_ovf <= (w_op_a[SLICE-1] == w_op_b[SLICE-1]) &
                                         (w_slc[SLICE-1] != w_op_a[SLICE-1]);
            end
            assign w_ovf = r_ovf;
        end
`endif
    end

    assign in_ready  = w_adv;
    assign out_valid = w_v[c_STAGES-1];
    assign s         = w_lo[c_LO_TOT-1 -: WIDTH];
    assign cout      = w_c[c_STAGES-1];
    assign G         = w_g[c_STAGES-1];
    assign P         = w_p[c_STAGES-1];
`ifdef ALU_FLAGS_EN
    assign flags     = {s[WIDTH-1], w_z[c_STAGES-1], w_c[c_STAGES-1], w_ovf};
`else
    assign flags     = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipelined_cla_adder                                          |
// | Purpose  : Scoreboard bench for pipelined_cla_adder (WIDTH=64, SLICE=16).  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pipelined_cla_adder;

    localparam int WIDTH  = 64;
    localparam int SLICE  = 16;
    localparam int STAGES = WIDTH / SLICE;

`ifdef ALU_FLAGS_EN
    localparam logic [3:0] c_F_T1 = 4'b1001;
    localparam logic [3:0] c_F_Z  = 4'b0110;
`else
    localparam logic [3:0] c_F_T1 = 4'b0000;
    localparam logic [3:0] c_F_Z  = 4'b0000;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             g;
        logic             p;
        logic [3:0]       flags;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             G;
    logic             P;
    logic [3:0]       flags;

    res_t exp_q[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    res_t cur;
    res_t held;
    logic stalled = 1'b0;

    pipelined_cla_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .G(G), .P(P), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain wide arithmetic on the effective operand.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci, input logic sb);
        logic [WIDTH-1:0] be;
        logic [WIDTH:0]   full;
        logic [WIDTH:0]   gen;
        res_t             r;
        be      = sb ? ~y : y;
        full    = {1'b0, x} + {1'b0, be} + {{WIDTH{1'b0}}, ci};
        gen     = {1'b0, x} + {1'b0, be};
        r.s     = full[WIDTH-1:0];
        r.cout  = full[WIDTH];
        r.g     = gen[WIDTH];
        r.p     = &(x ^ be);
`ifdef ALU_FLAGS_EN
        r.flags = {r.s[WIDTH-1], r.s == '0, r.cout,
                   (x[WIDTH-1] == be[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1])};
`else
        r.flags = 4'b0000;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks hold-stability during stalls.
    always @(negedge clk) begin
        cur = {s, cout, G, P, flags};
        if (stalled) check("hold_stable", {out_valid, cur}, {1'b1, held});
        if (out_valid && !out_ready) check("in_ready_stall", {127'b0, in_ready}, 128'b0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got %h, required no result", cur);
            end else begin
                check("result", cur, exp_q.pop_front());
            end
        end
        stalled = out_valid && !out_ready;
        held    = cur;
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic sb, input res_t e, output int waits);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        waits = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                exp_q.push_back(e);
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        if (waits == 50) check("send_timeout", 128'(waits), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic send_rand(output int waits);
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             ci;
        logic             sb;
        x  = {$urandom, $urandom};
        y  = {$urandom, $urandom};
        ci = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        send(x, y, ci, sb, model(x, y, ci, sb), waits);
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check(name, 128'(exp_q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        int wsum;
        int lat;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {127'b0, out_valid}, 128'd0);
        check("reset_outputs", {s, cout, G, P, flags}, 128'd0);
        check("reset_in_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk); #1;

        // Signed overflow into the MSB, latency from an idle pipeline.
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             {64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, c_F_T1}, w);
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc_cyc;
                break;
            end
        end
        check("latency", 128'(lat), 128'(STAGES));
        @(posedge clk); #1;

        send(64'd5, 64'd5, 1'b1, 1'b1, {64'd0, 1'b1, 1'b0, 1'b1, c_F_Z}, w);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, {64'd0, 1'b1, 1'b0, 1'b1, c_F_Z}, w);
        send(64'd3, 64'd9, 1'b0, 1'b1, model(64'd3, 64'd9, 1'b0, 1'b1), w);
        drain("drain_directed");

        // Back-to-back stream with a 4-cycle consumer stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand(w);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset with three operations in flight; none may emerge.
        for (int i = 0; i < 3; i++) send_rand(w);
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_flush_valid", {127'b0, out_valid}, 128'd0);
        check("rst_in_ready", {127'b0, in_ready}, 128'd1);
        repeat (10) @(posedge clk);
        #1;

        // Full-throughput random stream.
        wsum = 0;
        for (int i = 0; i < 100; i++) begin
            send_rand(w);
            wsum += w;
        end
        check("full_throughput", 128'(wsum), 128'd0);
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
